// File: rtl/text_console_ctrl.sv
// text_console_ctrl: command-driven controller for a character-cell text screen.
//
// Accepts PUT / NEWLINE / CLEAR / HOME commands and turns them into write (and,
// for scrolling, read) cycles on an external screen memory with one-cycle read
// latency. The screen is ROWS x COLS cells, addressed row*COLS+col.
//
// Ports:
//   clock      in   single clock, all state updates on the rising edge
//   reset      in   synchronous active-high reset
//   cmd_valid  in   command offered
//   cmd_ready  out  controller idle and able to take a command this cycle
//   cmd_op     in   00 PUT, 01 NEWLINE, 10 CLEAR, 11 HOME
//   cmd_char   in   character code for PUT
//   mem_addr   out  screen memory address
//   mem_wr     out  screen memory write enable
//   mem_wdata  out  screen memory write data
//   mem_rdata  in   screen memory read data (valid one cycle after the address)
//   cursor_col out  current cursor column
//   cursor_row out  current cursor row
//   busy       out  high whenever a multi-cycle operation is in progress
module text_console_ctrl #(
  parameter int unsigned NlocC  = 1200,
  parameter int unsigned DbitsC = 4,
  parameter int unsigned COLS   = 40,
  parameter int unsigned ROWS   = 30,
  parameter int unsigned BLANK  = 0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [1:0]                 cmd_op,
  input  logic [DbitsC-1:0]          cmd_char,
  output logic [$clog2(NlocC)-1:0]   mem_addr,
  output logic                       mem_wr,
  output logic [DbitsC-1:0]          mem_wdata,
  input  logic [DbitsC-1:0]          mem_rdata,
  output logic [$clog2(COLS)-1:0]    cursor_col,
  output logic [$clog2(ROWS)-1:0]    cursor_row,
  output logic                       busy
);

  localparam int unsigned AddrW = $clog2(NlocC);
  localparam int unsigned ColW  = $clog2(COLS);
  localparam int unsigned RowW  = $clog2(ROWS);

  localparam logic [ColW-1:0]   LastCol    = ColW'(COLS - 1);
  localparam logic [RowW-1:0]   LastRow    = RowW'(ROWS - 1);
  localparam logic [AddrW-1:0]  LastAddr   = AddrW'(NlocC - 1);
  // Last destination address of the row-copy phase of a scroll.
  localparam logic [AddrW-1:0]  CopyLast   = AddrW'(NlocC - COLS - 1);
  // First cell of the bottom row, where the blank fill starts.
  localparam logic [AddrW-1:0]  FillFirst  = AddrW'(NlocC - COLS);
  localparam logic [AddrW-1:0]  RowStride  = AddrW'(COLS);
  localparam logic [DbitsC-1:0] BlankChar  = DbitsC'(BLANK);

  localparam logic [1:0] OpPut     = 2'b00;
  localparam logic [1:0] OpNewline = 2'b01;
  localparam logic [1:0] OpClear   = 2'b10;
  localparam logic [1:0] OpHome    = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StPut,
    StClear,
    StScrollRd,
    StScrollWr,
    StFill
  } state_e;

  state_e             state_q, state_d;
  logic [ColW-1:0]    col_q, col_d;
  logic [RowW-1:0]    row_q, row_d;
  logic [AddrW-1:0]   a_q, a_d;
  logic [DbitsC-1:0]  char_q, char_d;

  logic [AddrW-1:0]   cur_addr;
  logic               accept;

  // Cursor address computed entirely at memory-address width.
  assign cur_addr = AddrW'(row_q) * RowStride + AddrW'(col_q);

  assign cmd_ready  = (state_q == StIdle) && !reset;
  assign busy       = (state_q != StIdle) && !reset;
  assign accept     = cmd_valid && cmd_ready;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      a_q     <= '0;
      char_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      a_q     <= a_d;
      char_q  <= char_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    a_d       = a_q;
    char_d    = char_q;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (cmd_op)
            OpPut: begin
              char_d  = cmd_char;
              state_d = StPut;
            end
            OpNewline: begin
              col_d = '0;
              if (row_q < LastRow) begin
                row_d = row_q + RowW'(1);
              end else begin
                a_d     = '0;
                state_d = StScrollRd;
              end
            end
            OpClear: begin
              a_d     = '0;
              state_d = StClear;
            end
            OpHome: begin
              col_d = '0;
              row_d = '0;
            end
            default: ;
          endcase
        end
      end

      StPut: begin
        mem_wr    = 1'b1;
        mem_addr  = cur_addr;
        mem_wdata = char_q;
        if (col_q < LastCol) begin
          col_d   = col_q + ColW'(1);
          state_d = StIdle;
        end else begin
          col_d = '0;
          if (row_q < LastRow) begin
            row_d   = row_q + RowW'(1);
            state_d = StIdle;
          end else begin
            // Wrapped off the bottom row: scroll, cursor stays on the last row.
            a_d     = '0;
            state_d = StScrollRd;
          end
        end
      end

      StClear: begin
        mem_wr    = 1'b1;
        mem_addr  = a_q;
        mem_wdata = BlankChar;
        if (a_q == LastAddr) begin
          a_d     = '0;
          col_d   = '0;
          row_d   = '0;
          state_d = StIdle;
        end else begin
          a_d = a_q + AddrW'(1);
        end
      end

      StScrollRd: begin
        // Fetch the cell one row below the destination.
        mem_addr = a_q + RowStride;
        state_d  = StScrollWr;
      end

      StScrollWr: begin
        mem_wr    = 1'b1;
        mem_addr  = a_q;
        mem_wdata = mem_rdata;
        if (a_q < CopyLast) begin
          a_d     = a_q + AddrW'(1);
          state_d = StScrollRd;
        end else begin
          a_d     = FillFirst;
          state_d = StFill;
        end
      end

      StFill: begin
        mem_wr    = 1'b1;
        mem_addr  = a_q;
        mem_wdata = BlankChar;
        if (a_q == LastAddr) begin
          a_d     = '0;
          state_d = StIdle;
        end else begin
          a_d = a_q + AddrW'(1);
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Reset must silence the memory port within the same cycle it is raised,
    // so an in-flight clear/scroll never gets one more write in.
    if (reset) begin
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

endmodule
